// File: rtl/spi_regfile_rw.sv
`default_nettype none
// ============================================================================
// Module  : spi_regfile_rw
// Brief   : SPI mode-0 peripheral with register file, CIPO read-back and a
//           saturating rejected-frame counter; all inputs oversampled on clk.
// Rev     : 1.0
// ============================================================================

module spi_regfile_rw #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SCLK,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic                       CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [ERR_W-1:0]           err_cnt
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int HDR_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0]  C_HDR      = CNT_W'(HDR_W);
  localparam logic [CNT_W-1:0]  C_FRAME    = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  C_CNT_SAT  = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   C_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);

  // synchronisers and delayed copies for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic                   sclk_prev_q, ncs_prev_q;

  // frame state
  logic [CNT_W-1:0]          cnt_q,       cnt_d;
  logic                      rw_q,        rw_d;
  logic [FRAME_W-2:0]        shift_in_q,  shift_in_d;
  logic [DATA_W-1:0]         shift_out_q, shift_out_d;
  logic                      cipo_q,      cipo_d;

  // register file side
  logic [NUM_REGS*DATA_W-1:0] regs_d;
  logic                       wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]          wr_addr_q,   wr_addr_d;
  logic [ERR_W-1:0]           err_cnt_q,   err_cnt_d;

  logic              sclk_s, ncs_s, copi_s;
  logic              sclk_rise, sclk_fall, ncs_rise;
  logic [ADDR_W-1:0] frame_addr, rd_addr;
  logic [DATA_W-1:0] frame_data, rd_data;
  logic              addr_ok, commit_ok, frame_err;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;

  // The R/W bit lives in rw_q, so shift_in holds only {addr, data}
  assign frame_addr = shift_in_q[DATA_W +: ADDR_W];
  assign frame_data = shift_in_q[DATA_W-1:0];
  assign rd_addr    = shift_in_q[ADDR_W-1:0];

  assign addr_ok   = ({1'b0, frame_addr} < C_NUM_REGS);
  assign commit_ok = rw_q && (cnt_q == C_FRAME) && addr_ok;
  assign frame_err = (cnt_q < C_HDR) || (rw_q && !commit_ok);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  nCS};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], COPI};

    cnt_d       = cnt_q;
    rw_d        = rw_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    cipo_d      = cipo_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_cnt_d   = err_cnt_q;

    if (ncs_s) begin
      // Idle also covers the nCS-rise cycle, so a coincident SCLK edge is dropped
      cnt_d       = '0;
      rw_d        = 1'b0;
      shift_in_d  = '0;
      shift_out_d = '0;
      cipo_d      = 1'b0;
      if (ncs_rise) begin
        if (commit_ok) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (frame_addr == ADDR_W'(i)) regs_d[i*DATA_W +: DATA_W] = frame_data;
          end
          wr_addr_d   = frame_addr;
          wr_strobe_d = 1'b1;
        end else if (frame_err && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end
    end else begin
      if (sclk_rise) begin
        if (cnt_q == '0) begin
          rw_d = copi_s;
        end else if (cnt_q < C_FRAME) begin
          shift_in_d = {shift_in_q[FRAME_W-3:0], copi_s};
        end
        if (cnt_q != C_CNT_SAT) cnt_d = cnt_q + 1'b1;
      end else if (sclk_fall && !rw_q && (cnt_q >= C_HDR)) begin
        if (cnt_q == C_HDR) begin
          cipo_d      = rd_data[DATA_W-1];
          shift_out_d = {rd_data[DATA_W-2:0], 1'b0};
        end else begin
          cipo_d      = shift_out_q[DATA_W-1];
          shift_out_d = {shift_out_q[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '1;
      copi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      cipo_q      <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      copi_sync_q <= copi_sync_d;
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      cipo_q      <= cipo_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign CIPO      = cipo_q & ~ncs_s;
  assign CIPO_oe   = ~ncs_s;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire
